// File: rtl/lean_conv_monitor.sv
// Multi-channel settling/convergence monitor: band-entry time, hold-to-pass and timeout per channel.
// Optional macro CONV_OVERSHOOT_EN adds peak_ovs_o (largest |err| seen after first band entry).

module lean_conv_monitor_ch #(
  parameter int WIDTH   = 16,
  parameter int TOL     = 64,
  parameter int HOLD    = 1024,
  parameter int TIMEOUT = 2000000,
  parameter int CW      = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm_i,
  input  logic signed [WIDTH-1:0] tgt_i,
  input  logic signed [WIDTH-1:0] meas_i,
  input  logic                    meas_vld_i,
  output logic                    active_o,
  output logic                    conv_o,
  output logic                    tmo_o,
  output logic [CW-1:0]           settle_o
`ifdef CONV_OVERSHOOT_EN
  ,
  output logic [WIDTH-1:0]        peak_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_HOLD, S_PASS, S_FAIL} st_e;
  localparam int HW = $clog2(HOLD + 1);

  st_e                     st_q;
  logic signed [WIDTH-1:0] tgt_q;
  logic [CW-1:0]           elapsed_q, settle_q;
  logic [HW-1:0]           hold_q;
  logic                    conv_q, tmo_q;

  logic signed [WIDTH:0]   err;
  logic [WIDTH:0]          aerr;
  logic [HW-1:0]           hold_inc;
  logic                    in_band, vin, vout, tmo_hit, hold_done, run;

  // One extra bit keeps meas - tgt exact across the full signed range.
  assign err       = {meas_i[WIDTH-1], meas_i} - {tgt_q[WIDTH-1], tgt_q};
  assign aerr      = err[WIDTH] ? $unsigned(-err) : $unsigned(err);
  assign in_band   = aerr <= (WIDTH+1)'(TOL);
  assign vin       = meas_vld_i & in_band;
  assign vout      = meas_vld_i & ~in_band;
  assign tmo_hit   = elapsed_q >= CW'(TIMEOUT - 1);
  assign hold_inc  = hold_q + HW'(1);
  assign hold_done = hold_inc == HW'(HOLD);
  assign run       = (st_q == S_SETTLE) || (st_q == S_HOLD);

`ifdef CONV_OVERSHOOT_EN
  logic             ent_q;
  logic [WIDTH-1:0] peak_q, aerr_sat;
  assign aerr_sat = aerr[WIDTH] ? '1 : aerr[WIDTH-1:0];
  assign peak_o   = peak_q;
`endif

  // The arm clock is elapsed 0, so the first evaluated clock after arm sees elapsed 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= S_IDLE;
      tgt_q     <= '0;
      elapsed_q <= '0;
      settle_q  <= '0;
      hold_q    <= '0;
      conv_q    <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef CONV_OVERSHOOT_EN
      ent_q     <= 1'b0;
      peak_q    <= '0;
`endif
    end else if (arm_i) begin
      st_q      <= S_SETTLE;
      tgt_q     <= tgt_i;
      elapsed_q <= CW'(1);
      settle_q  <= '0;
      hold_q    <= '0;
      conv_q    <= 1'b0;
      tmo_q     <= 1'b0;
`ifdef CONV_OVERSHOOT_EN
      ent_q     <= 1'b0;
      peak_q    <= '0;
`endif
    end else if (run) begin
      elapsed_q <= elapsed_q + CW'(1);
      if (vin && hold_done) begin
        st_q   <= S_PASS;
        conv_q <= 1'b1;
        hold_q <= hold_inc;
        if (st_q == S_SETTLE) settle_q <= elapsed_q;
      end else if (tmo_hit) begin
        st_q     <= S_FAIL;
        tmo_q    <= 1'b1;
        settle_q <= '1;
      end else if (vin) begin
        st_q   <= S_HOLD;
        hold_q <= hold_inc;
        if (st_q == S_SETTLE) settle_q <= elapsed_q;
      end else if (vout) begin
        st_q   <= S_SETTLE;
        hold_q <= '0;
      end
`ifdef CONV_OVERSHOOT_EN
      if (vin) ent_q <= 1'b1;
      if (meas_vld_i && (ent_q || in_band) && (aerr_sat > peak_q)) peak_q <= aerr_sat;
`endif
    end
  end

  assign active_o = run;
  assign conv_o   = conv_q;
  assign tmo_o    = tmo_q;
  assign settle_o = settle_q;

endmodule

module lean_conv_monitor #(
  parameter int NCH     = 2,
  parameter int WIDTH   = 16,
  parameter int TOL     = 64,
  parameter int HOLD    = 1024,
  parameter int TIMEOUT = 2000000,
  parameter int CW      = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm_i,
  input  logic [NCH*WIDTH-1:0] target_i,
  input  logic [NCH*WIDTH-1:0] meas_i,
  input  logic                 meas_vld_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NCH-1:0]       converged_o,
  output logic [NCH-1:0]       timeout_err_o,
  output logic [NCH*CW-1:0]    settle_cyc_o
`ifdef CONV_OVERSHOOT_EN
  ,
  output logic [NCH*WIDTH-1:0] peak_ovs_o
`endif
);

  logic [NCH-1:0] active;
  logic           busy_dly_q, done_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    lean_conv_monitor_ch #(
      .WIDTH(WIDTH), .TOL(TOL), .HOLD(HOLD), .TIMEOUT(TIMEOUT), .CW(CW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm_i      (arm_i),
      .tgt_i      (target_i[g*WIDTH +: WIDTH]),
      .meas_i     (meas_i[g*WIDTH +: WIDTH]),
      .meas_vld_i (meas_vld_i),
      .active_o   (active[g]),
      .conv_o     (converged_o[g]),
      .tmo_o      (timeout_err_o[g]),
      .settle_o   (settle_cyc_o[g*CW +: CW])
`ifdef CONV_OVERSHOOT_EN
      ,
      .peak_o     (peak_ovs_o[g*WIDTH +: WIDTH])
`endif
    );
  end

  assign busy_o = |active;

  // An arm keeps busy high across the restart, so an aborted run never shows a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_dly_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_dly_q <= busy_o;
      done_q     <= busy_dly_q & ~busy_o;
    end
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_lean_conv_monitor.sv
// Scoreboarded bench for lean_conv_monitor: expected end-of-run results queued at arm, checked on done.
module tb_lean_conv_monitor;
  localparam int NCH = 2, WIDTH = 16, TOL = 64, HOLD = 8, TIMEOUT = 100, CW = 22;

  logic                 clk = 1'b0;
  logic                 rst_n, arm, mv;
  logic [NCH*WIDTH-1:0] tgt, meas;
  logic                 busy, done;
  logic [NCH-1:0]       conv, tmo;
  logic [NCH*CW-1:0]    settle;
`ifdef CONV_OVERSHOOT_EN
  logic [NCH*WIDTH-1:0] peak;
`endif

  typedef struct {
    logic [1:0]    conv;
    logic [1:0]    tmo;
    logic [CW-1:0] s0;
    logic [CW-1:0] s1;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0, done_cnt = 0;

  always #5 clk = ~clk;

  lean_conv_monitor #(
    .NCH(NCH), .WIDTH(WIDTH), .TOL(TOL), .HOLD(HOLD), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .arm_i         (arm),
    .target_i      (tgt),
    .meas_i        (meas),
    .meas_vld_i    (mv),
    .busy_o        (busy),
    .done_o        (done),
    .converged_o   (conv),
    .timeout_err_o (tmo),
    .settle_cyc_o  (settle)
`ifdef CONV_OVERSHOOT_EN
    ,
    .peak_ovs_o    (peak)
`endif
  );

  // Scoreboard consumer: each done pops one expected run result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL done_unexpected: done pulsed with no run expected (conv=%b tmo=%b)", conv, tmo);
        bad++;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({conv, tmo, settle[CW-1:0], settle[2*CW-1:CW]} !== {e.conv, e.tmo, e.s0, e.s1}) begin
          $display("FAIL done_result: got conv=%b tmo=%b s0=%0d s1=%0d want conv=%b tmo=%b s0=%0d s1=%0d",
                   conv, tmo, settle[CW-1:0], settle[2*CW-1:CW], e.conv, e.tmo, e.s0, e.s1);
          bad++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int t0, input int t1);
    tgt  = {16'(t1), 16'(t0)};
    arm  = 1'b1;
    mv   = 1'b1;
    step();
    arm  = 1'b0;
  endtask

  task automatic drive(input int m0, input int m1, input logic v);
    meas = {16'(m1), 16'(m0)};
    mv   = v;
    step();
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      $display("FAIL %s: got %0h want %0h", name, got, want);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b1; mv = 1'b0; tgt = '0; meas = '0;
    for (int i = 0; i < 4; i++) begin
      meas = {$urandom, $urandom}; mv = ~mv;
      step();
    end
    total++;
    if ({busy, done, conv, tmo, settle} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b conv=%b tmo=%b settle=%h want all 0",
               busy, done, conv, tmo, settle);
      bad++;
    end
    arm = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(int'($urandom_range(0, 200)), 0, 1'b1);
    total++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      $display("FAIL reset_idle: got busy=%b dones=%0d want busy=0 dones=0", busy, done_cnt);
      bad++;
    end
  endtask

  task automatic test_step_pass();
    int d0, m;
    exp_q.push_back('{conv: 2'b11, tmo: 2'b00, s0: 9, s1: 9});
    d0 = done_cnt;
    do_arm(0, 0);
    for (int j = 1; j <= 16; j++) begin
      m = 4000 - 500 * (j - 1);
      if (m < 0) m = 0;
      drive(m, m, 1'b1);
      if (j == 8) begin
        total++;
        if (conv !== 2'b00 || busy !== 1'b1) begin
          $display("FAIL step_pre_entry: got conv=%b busy=%b want conv=00 busy=1", conv, busy); bad++;
        end
      end
      if (j == 9) begin
        total++;
        if (settle[CW-1:0] !== 9 || settle[2*CW-1:CW] !== 9) begin
          $display("FAIL step_settle: got %0d/%0d want 9/9", settle[CW-1:0], settle[2*CW-1:CW]); bad++;
        end
      end
      if (j == 15) begin
        total++;
        if (conv !== 2'b00) begin $display("FAIL step_early_pass: got conv=%b want 00", conv); bad++; end
      end
    end
    total++;
    if (conv !== 2'b11 || busy !== 1'b0) begin
      $display("FAIL step_pass: got conv=%b busy=%b want conv=11 busy=0", conv, busy); bad++;
    end
    mv = 1'b0;
    step();
    total++;
    if (done !== 1'b1) begin $display("FAIL step_done_pulse: got done=%b want 1", done); bad++; end
    step(); step();
    total++;
    if (done_cnt != d0 + 1) begin
      $display("FAIL step_done_count: got %0d want %0d", done_cnt - d0, 1); bad++;
    end
  endtask

  task automatic test_relapse();
    int   d0;
    int   m0_tab[18] = '{0, 0, 1010, 1010, 1010, 1010, 1010, 1065, 0, 936,
                         1000, 0, 1000, 1000, 1000, 1000, 1000, 1000};
    logic v_tab[18]  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    exp_q.push_back('{conv: 2'b11, tmo: 2'b00, s0: 10, s1: 1});
    d0 = done_cnt;
    do_arm(1000, -200);
    for (int c = 1; c <= 18; c++) begin
      drive(m0_tab[c-1], -190, v_tab[c-1]);
      if (c == 7)  chk("relapse_entry", 64'(settle[CW-1:0]), 64'd3);
      if (c == 8)  chk("relapse_out_keep", 64'({conv, settle[CW-1:0]}), 64'({2'b10, 22'd3}));
      if (c == 9)  chk("relapse_novld", 64'({busy, settle[CW-1:0]}), 64'({1'b1, 22'd3}));
      if (c == 10) chk("relapse_reentry", 64'(settle[CW-1:0]), 64'd10);
      if (c == 17) chk("relapse_not_yet", 64'(conv), 64'(2'b10));
    end
    chk("relapse_pass", 64'({conv, busy}), 64'({2'b11, 1'b0}));
    step(); step(); step();
    chk("relapse_done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic test_timeout();
    int d0;
    exp_q.push_back('{conv: 2'b01, tmo: 2'b10, s0: 1, s1: '1});
    d0 = done_cnt;
    do_arm(0, 0);
    for (int c = 1; c <= 99; c++) begin
      drive(5, 1000, 1'b1);
      if (c == 8)  chk("tmo_ch0_pass", 64'(conv), 64'(2'b01));
      if (c == 98) chk("tmo_not_yet", 64'({tmo, busy}), 64'({2'b00, 1'b1}));
    end
    chk("tmo_fire", 64'({tmo, busy, settle[2*CW-1:CW]}), 64'({2'b10, 1'b0, 22'h3FFFFF}));
    step(); step(); step();
    chk("tmo_done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic test_rearm();
    int d0;
    do_arm(0, 0);
    for (int c = 1; c <= 4; c++) drive(0, 0, 1'b1);
    d0 = done_cnt;
    exp_q.push_back('{conv: 2'b11, tmo: 2'b00, s0: 4, s1: 1});
    do_arm(32767, 0);
    chk("rearm_clear", 64'({conv, tmo, busy, settle}), 64'({2'b00, 2'b00, 1'b1, 44'd0}));
    for (int c = 1; c <= 11; c++) begin
      drive(c <= 3 ? -32768 : 32767, 0, 1'b1);
      if (c == 1) chk("rearm_elapsed_restart", 64'(settle[2*CW-1:CW]), 64'd1);
      if (c == 3) chk("rearm_no_overflow", 64'(settle[CW-1:0]), 64'd0);
    end
    chk("rearm_pass", 64'({conv, busy}), 64'({2'b11, 1'b0}));
    step(); step(); step();
    chk("rearm_done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic test_timeout_edge();
    int d0;
    exp_q.push_back('{conv: 2'b11, tmo: 2'b00, s0: 1, s1: 92});
    d0 = done_cnt;
    do_arm(0, 0);
    for (int c = 1; c <= 99; c++) drive(0, c < 92 ? 1000 : 0, 1'b1);
    chk("edge_pass_wins", 64'({conv, tmo, settle[2*CW-1:CW]}), 64'({2'b11, 2'b00, 22'd92}));
    step(); step(); step();
    chk("edge_done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic test_overshoot();
    int d0;
    int m0_tab[9] = '{500, 0, -60, 30, 0, 0, 0, 0, 0};
    exp_q.push_back('{conv: 2'b11, tmo: 2'b00, s0: 2, s1: 1});
    d0 = done_cnt;
    do_arm(0, 0);
    for (int c = 1; c <= 9; c++) begin
      drive(m0_tab[c-1], 0, 1'b1);
`ifdef CONV_OVERSHOOT_EN
      if (c == 4) chk("ovs_peak", 64'(peak), 64'({16'd0, 16'd60}));
`endif
    end
    chk("ovs_pass", 64'({conv, settle[CW-1:0]}), 64'({2'b11, 22'd2}));
`ifdef CONV_OVERSHOOT_EN
    drive(500, 500, 1'b1);
    chk("ovs_frozen", 64'(peak), 64'({16'd0, 16'd60}));
    step(); step();
`else
    step(); step(); step();
`endif
    chk("ovs_done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic test_reset_midrun();
    int d0;
    do_arm(0, 0);
    for (int c = 1; c <= 3; c++) drive(0, 0, 1'b1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midreset_clear", 64'({busy, done, conv, tmo, settle}), 64'd0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) drive(0, 0, 1'b0);
    chk("midreset_no_done", 64'({busy, 32'(done_cnt - d0)}), 64'd0);
  endtask

  initial begin
    test_reset();
    test_step_pass();
    test_relapse();
    test_timeout();
    test_rearm();
    test_timeout_edge();
    test_overshoot();
    test_reset_midrun();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
